// File: rtl/fifo_sched_if.sv
// Request/response bundle between producers, consumer, scheduler and the FIFO.
// The scheduler uses the slave modport; the environment drives through master.
interface fifo_sched_if #(
  parameter int DATA_W = 4
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              del_req;
  logic              del_ack;
  logic              f_we;
  logic              f_re;
  logic              f_del;
  logic [DATA_W-1:0] f_din;
  logic [DATA_W-1:0] f_dout;
  logic              f_empty;
  logic              f_full;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, rd_req, del_req, f_dout, f_empty, f_full,
    output a_ready, b_ready, rd_valid, rd_data, del_ack, f_we, f_re, f_del, f_din
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, rd_req, del_req, f_dout, f_empty, f_full,
    input  a_ready, b_ready, rd_valid, rd_data, del_ack, f_we, f_re, f_del, f_din
  );
endinterface

// File: rtl/fifo_sched.sv
// Scheduler arbitrating two writers, one reader and a delete-last requester onto one FIFO.
// Optional macro FIFO_SCHED_LEVEL_EN adds the `level` occupancy port and counter.
module fifo_sched #(
  parameter int DATA_W = 4,
  parameter int AW     = 8
) (
  input  logic         clk,
  input  logic         rst,
  fifo_sched_if.slave  bus
`ifdef FIFO_SCHED_LEVEL_EN
  ,
  output logic [AW:0]  level
`endif
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_OUT, DEL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_b;
  logic              w_grant_b;
  logic              w_any_wr;
  logic              w_f_we;
  logic              w_f_re;
  logic              w_f_del;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_rd_valid;
  logic [DATA_W-1:0] w_f_din;
  logic [DATA_W-1:0] w_rd_data;
  logic              r_f_we;
  logic              r_f_re;
  logic              r_f_del;
  logic              r_a_ready;
  logic              r_b_ready;
  logic              r_rd_valid;
  logic              r_del_ack;
  logic [DATA_W-1:0] r_f_din;
  logic [DATA_W-1:0] r_rd_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the strobe values that will be registered alongside it
  always_comb begin
    w_state_nxt = r_state;
    w_any_wr    = (bus.a_valid | bus.b_valid) & ~bus.f_full;
    if (bus.a_valid && bus.b_valid) begin
      w_grant_b = ~r_last_b;
    end else begin
      w_grant_b = bus.b_valid;
    end
    case (r_state)
      IDLE: begin
        if (bus.del_req && !bus.f_empty) begin
          w_state_nxt = DEL;
        end else if (bus.rd_req && !bus.f_empty) begin
          w_state_nxt = RD;
        end else if (w_any_wr) begin
          w_state_nxt = WR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD:      w_state_nxt = RD_OUT;
      WR:      w_state_nxt = IDLE;
      RD_OUT:  w_state_nxt = IDLE;
      DEL:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_f_we     = (w_state_nxt == WR);
    w_f_re     = (w_state_nxt == RD);
    w_f_del    = (w_state_nxt == DEL);
    w_rd_valid = (w_state_nxt == RD_OUT);
    w_a_ready  = w_f_we & ~w_grant_b;
    w_b_ready  = w_f_we & w_grant_b;
    if (w_f_we) begin
      w_f_din = w_grant_b ? bus.b_data : bus.a_data;
    end else begin
      w_f_din = {DATA_W{1'b0}};
    end
    // FIFO is show-ahead: f_dout already holds the head during the RD cycle
    if (w_rd_valid) begin
      w_rd_data = bus.f_dout;
    end else begin
      w_rd_data = r_rd_data;
    end
  end

  // Registered handshake outputs and writer round-robin memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_we     <= 1'b0;
      r_f_re     <= 1'b0;
      r_f_del    <= 1'b0;
      r_a_ready  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_del_ack  <= 1'b0;
      r_f_din    <= {DATA_W{1'b0}};
      r_rd_data  <= {DATA_W{1'b0}};
      r_last_b   <= 1'b1;
    end else begin
      r_f_we     <= w_f_we;
      r_f_re     <= w_f_re;
      r_f_del    <= w_f_del;
      r_a_ready  <= w_a_ready;
      r_b_ready  <= w_b_ready;
      r_rd_valid <= w_rd_valid;
      r_del_ack  <= w_f_del;
      r_f_din    <= w_f_din;
      r_rd_data  <= w_rd_data;
      if (w_f_we) begin
        r_last_b <= w_grant_b;
      end else begin
        r_last_b <= r_last_b;
      end
    end
  end

  assign bus.f_we     = r_f_we;
  assign bus.f_re     = r_f_re;
  assign bus.f_del    = r_f_del;
  assign bus.f_din    = r_f_din;
  assign bus.a_ready  = r_a_ready;
  assign bus.b_ready  = r_b_ready;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.del_ack  = r_del_ack;

`ifdef FIFO_SCHED_LEVEL_EN
  logic [AW:0] r_level;

  // Occupancy follows the strobes as the FIFO commits them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= {(AW+1){1'b0}};
    end else if (r_f_we && (r_level != {1'b1, {AW{1'b0}}})) begin
      r_level <= r_level + {{AW{1'b0}}, 1'b1};
    end else if ((r_f_re || r_f_del) && (r_level != {(AW+1){1'b0}})) begin
      r_level <= r_level - {{AW{1'b0}}, 1'b1};
    end else begin
      r_level <= r_level;
    end
  end

  assign level = r_level;
`endif

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: behavioural FIFO, rule-based monitor, vector table and random traffic.
module tb_fifo_sched;
  localparam int DW    = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_sched_if #(.DATA_W(DW)) bus();
`ifdef FIFO_SCHED_LEVEL_EN
  logic [AW:0] level;
`endif

  fifo_sched #(.DATA_W(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef FIFO_SCHED_LEVEL_EN
    ,
    .level (level)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd[$];
  int            op_code[$];   // 1 WR-A, 2 WR-B, 3 RD, 4 DEL
  logic [DW-1:0] op_din[$];
  bit            lvl_track = 1'b0;
  bit            last_g_b  = 1'b1;
  bit p_we, p_re, p_de, p_rv;
  logic [DW-1:0] p_din;

  typedef struct {
    int pre; bit av; logic [3:0] ad; bit bv; logic [3:0] bd;
    bit rd; bit del; int op; logic [3:0] din;
  } vec_t;
  vec_t vt[12];

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void set_flags();
    bus.f_dout  = (q.size() > 0) ? q[0] : '0;
    bus.f_empty = (q.size() == 0);
    bus.f_full  = (q.size() == DEPTH);
  endfunction

  // Rules checked once per cycle on the freshly registered outputs
  function automatic void monitor();
    int  n_str;
    bit  cw, cr, cd, ar, br, rv;
    bit  empty;
    cw = bus.f_we; cr = bus.f_re; cd = bus.f_del;
    ar = bus.a_ready; br = bus.b_ready; rv = bus.rd_valid;
    empty = (q.size() == 0);
    n_str = int'(cw) + int'(cr) + int'(cd);
    check("strobe_overlap", int'(n_str > 1), 0);
    check("op_spacing", int'((n_str > 0) && (p_we || p_re || p_de || p_rv)), 0);
    check("rd_valid_after_re", rv, p_re);
    check("del_ack_with_del", bus.del_ack, cd);
    check("we_has_one_ready", int'(ar) + int'(br), int'(cw));
    if (ar) begin
      check("a_ready_needs_valid", bus.a_valid, 1);
      check("f_din_from_a", bus.f_din, bus.a_data);
    end
    if (br) begin
      check("b_ready_needs_valid", bus.b_valid, 1);
      check("f_din_from_b", bus.f_din, bus.b_data);
    end
    if (cw) begin
      if (bus.a_valid && bus.b_valid) check("rr_grant_b", br, int'(!last_g_b));
      last_g_b = br;
      check("wr_priority_guard",
            int'((bus.del_req && !empty) || (bus.rd_req && !empty) || q.size() == DEPTH), 0);
      op_code.push_back(ar ? 1 : 2);
      op_din.push_back(bus.f_din);
    end
    if (cr) begin
      check("rd_priority_guard", int'((bus.del_req && !empty) || empty), 0);
      op_code.push_back(3);
      op_din.push_back('0);
    end
    if (cd) begin
      check("del_guard", int'(empty), 0);
      op_code.push_back(4);
      op_din.push_back('0);
    end
    if (rv) begin
      check("rd_expected_pending", int'(exp_rd.size() > 0), 1);
      if (exp_rd.size() > 0) check("rd_data", bus.rd_data, exp_rd.pop_front());
    end
`ifdef FIFO_SCHED_LEVEL_EN
    if (lvl_track) check("level", int'(level), q.size());
`endif
  endfunction

  // Behavioural FIFO commits the strobes of the cycle that just ended
  always begin
    @(posedge clk);
    p_we = bus.f_we; p_re = bus.f_re; p_de = bus.f_del;
    p_rv = bus.rd_valid; p_din = bus.f_din;
    #1;
    if (!rst) begin
      last_g_b = 1'b1;
    end else begin
      if (p_re && q.size() > 0) begin
        exp_rd.push_back(q[0]);
        void'(q.pop_front());
      end
      if (p_we) q.push_back(p_din);
      if (p_de && q.size() > 0) void'(q.pop_back());
      set_flags();
      monitor();
    end
  end

  task automatic clear_inputs();
    bus.a_valid = 1'b0; bus.a_data = '0; bus.b_valid = 1'b0; bus.b_data = '0;
    bus.rd_req = 1'b0; bus.del_req = 1'b0;
  endtask

  task automatic do_reset(input int pre, input int base);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    q.delete(); exp_rd.delete(); op_code.delete(); op_din.delete();
    for (int i = 0; i < pre; i++) q.push_back(DW'(base + i));
    set_flags();
    last_g_b  = 1'b1;
    lvl_track = (pre == 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n_before;
    bit seen;
    clear_inputs();
    set_flags();
    vt[0]  = '{0,   1, 4'h3, 0, 4'h0, 0, 0, 1, 4'h3};
    vt[1]  = '{0,   0, 4'h0, 1, 4'h7, 0, 0, 2, 4'h7};
    vt[2]  = '{0,   1, 4'h9, 1, 4'hC, 0, 0, 1, 4'h9};
    vt[3]  = '{2,   0, 4'h0, 0, 4'h0, 1, 0, 3, 4'h0};
    vt[4]  = '{2,   0, 4'h0, 0, 4'h0, 0, 1, 4, 4'h0};
    vt[5]  = '{2,   0, 4'h0, 0, 4'h0, 1, 1, 4, 4'h0};
    vt[6]  = '{2,   1, 4'h2, 0, 4'h0, 1, 0, 3, 4'h0};
    vt[7]  = '{0,   0, 4'h0, 0, 4'h0, 1, 1, 0, 4'h0};
    vt[8]  = '{0,   0, 4'h0, 1, 4'h5, 1, 1, 2, 4'h5};
    vt[9]  = '{256, 1, 4'h6, 0, 4'h0, 0, 0, 0, 4'h0};
    vt[10] = '{256, 1, 4'h6, 0, 4'h0, 1, 0, 3, 4'h0};
    vt[11] = '{256, 0, 4'h0, 1, 4'hE, 0, 1, 4, 4'h0};

    for (int v = 0; v < 12; v++) begin
      int code;
      do_reset(vt[v].pre, 1);
      bus.a_valid = vt[v].av; bus.a_data = vt[v].ad;
      bus.b_valid = vt[v].bv; bus.b_data = vt[v].bd;
      bus.rd_req = vt[v].rd;  bus.del_req = vt[v].del;
      repeat (8) @(negedge clk);
      code = (op_code.size() > 0) ? op_code[0] : 0;
      check($sformatf("vec%0d_first_op", v), code, vt[v].op);
      if (code == 1 || code == 2) check($sformatf("vec%0d_din", v), op_din[0], vt[v].din);
    end

    // Reset forces every registered output low at once
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs", int'({bus.f_we, bus.f_re, bus.f_del, bus.a_ready, bus.b_ready,
                                 bus.rd_valid, bus.del_ack, bus.f_din, bus.rd_data}), 0);
`ifdef FIFO_SCHED_LEVEL_EN
    check("reset_level", int'(level), 0);
`endif

    // First write after release
    do_reset(0, 0);
    bus.a_valid = 1'b1; bus.a_data = 4'h3;
    @(posedge clk); #2;
    check("first_wr_we", bus.f_we, 1);
    check("first_wr_din", bus.f_din, 3);
    check("first_wr_a_ready", bus.a_ready, 1);
    @(negedge clk);
    bus.a_valid = 1'b0;
    @(posedge clk); #2;
    check("first_wr_ready_pulse", bus.a_ready, 0);
`ifdef FIFO_SCHED_LEVEL_EN
    check("first_wr_level", int'(level), 1);
`endif

    // Round robin with both producers held
    do_reset(0, 0);
    bus.a_valid = 1'b1; bus.a_data = 4'hA; bus.b_valid = 1'b1; bus.b_data = 4'hB;
    for (int c = 0; c < 20 && op_code.size() < 4; c++) @(negedge clk);
    check("rr_count", int'(op_code.size() >= 4), 1);
    if (op_code.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_code%0d", k), op_code[k], (k % 2 == 0) ? 1 : 2);
        check($sformatf("rr_din%0d", k), op_din[k], (k % 2 == 0) ? 10 : 11);
      end
    end

    // Read latency on a FIFO holding 5
    do_reset(1, 5);
    bus.rd_req = 1'b1;
    @(posedge clk); #2;
    check("lat_re_n1", bus.f_re, 1);
    check("lat_rv_n1", bus.rd_valid, 0);
    @(posedge clk); #2;
    check("lat_rv_n2", bus.rd_valid, 1);
    check("lat_data_n2", bus.rd_data, 5);
    check("lat_re_n2", bus.f_re, 0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    @(posedge clk); #2;
    check("lat_rv_n3", bus.rd_valid, 0);

    // Simultaneous delete, read and write, each dropped once served
    do_reset(2, 1);
    bus.del_req = 1'b1; bus.rd_req = 1'b1; bus.a_valid = 1'b1; bus.a_data = 4'h9;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.del_ack)  bus.del_req = 1'b0;
      if (bus.rd_valid) bus.rd_req  = 1'b0;
      if (bus.a_ready)  bus.a_valid = 1'b0;
    end
    check("prio_op_count", op_code.size(), 3);
    if (op_code.size() == 3) begin
      check("prio_op0", op_code[0], 4);
      check("prio_op1", op_code[1], 3);
      check("prio_op2", op_code[2], 1);
    end

    // Fill to full through the scheduler, then writes must stall
    do_reset(0, 0);
    bus.a_valid = 1'b1; bus.a_data = DW'($urandom);
    for (int c = 0; c < 700 && q.size() < DEPTH; c++) begin
      @(negedge clk);
      if (bus.a_ready) bus.a_data = DW'($urandom);
    end
    check("fill_reached_full", q.size(), DEPTH);
    n_before = op_code.size();
    repeat (10) @(negedge clk);
    check("full_no_more_writes", op_code.size(), n_before);
    check("full_a_ready_low", bus.a_ready, 0);
`ifdef FIFO_SCHED_LEVEL_EN
    check("full_level", int'(level), DEPTH);
`endif

    // Reset while a read is in flight
    do_reset(1, 5);
    bus.rd_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #2;
      seen = bus.f_re;
    end
    check("abort_rd_started", seen, 1);
    rst = 1'b0;
    #1;
    check("abort_f_re_low", bus.f_re, 0);
    check("abort_rd_valid_low", bus.rd_valid, 0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
      if (bus.rd_valid) seen = 1'b1;
    end
    check("abort_no_rd_valid", seen, 0);

    // Random traffic judged by the monitor rules and the FIFO scoreboard
    do_reset(0, 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.a_ready || !bus.a_valid) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_data  = DW'($urandom);
      end
      if (bus.b_ready || !bus.b_valid) begin
        bus.b_valid = ($urandom_range(0, 3) != 0);
        bus.b_data  = DW'($urandom);
      end
      bus.rd_req  = ($urandom_range(0, 99) < 35);
      bus.del_req = ($urandom_range(0, 99) < 10);
    end
    clear_inputs();
    repeat (6) @(negedge clk);
    check("random_no_pending_read", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
